// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared definitions for the UART transmit arbiter slice.
// Holds FSM state encodings, default sizing and the round-robin pointer helper.
// Optional build macro used by this slice: UART_ARB_FIXED_PRIO_EN (fixed priority pick).
package uart_tx_arbiter_pkg;

  // FSM encodings kept as plain vectors so older tools and waveform scripts
  // that decode the raw state value keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // Default sizing: 4 producers (2..8 supported), 2-bit grant id, 16-bit counter.
  localparam int NREQ_DEF  = 4;
  localparam int IDW_DEF   = 2;
  localparam int CNT_W_DEF = 16;

  // Index the next search starts from after granting requester w of n.
  function automatic int rr_next(input int w, input int n);
    return (w >= n - 1) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer-side holding-buffer handshake plus the UART transmitter link.
// Ports: req_valid/req_data/req_ready (one lane per producer, byte i at [8i+7:8i]),
//        tx_data/tx_ready toward the transmitter, tx_done back from it.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              tx_done;

  // master: the environment (producers and the transmitter)
  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data, tx_ready
  );

  // slave: the arbiter
  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data, tx_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick: combinational winner selection over the full-buffer vector.
// Latency: 0 cycles (pure logic). Backpressure: none, it only observes full/ptr.
// Ports: full (buffer occupancy), ptr (search start) -> winner index, any (something pending).
// With UART_ARB_FIXED_PRIO_EN defined the lowest full index wins and ptr is ignored.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] full,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any
);

`ifdef UART_ARB_FIXED_PRIO_EN

  // Scan from the top down so the lowest full index is the last one written.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (full[i]) begin
        winner = IDW'(i);
        any    = 1'b1;
      end
    end
  end

`else

  int             idx;
  logic [IDW-1:0] sel;

  // Walk NREQ slots starting at ptr, wrapping past NREQ-1; first full one wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (!any && full[sel]) begin
        any    = 1'b1;
        winner = sel;
      end
    end
  end

`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter among NREQ one-byte holding buffers.
// Latency: accept->grant 1 cycle, tx_ready rises on the grant edge; freed buffer re-accepts next cycle.
// Backpressure: req_ready[i] low while buffer i holds a byte; SEND waits on tx_done indefinitely.
// Ports: clk, rst (async, active-high), en (gates new grants), bus (slave modport),
//        busy, grant_id, sent_pulse, sent_count. Build macro: UART_ARB_FIXED_PRIO_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDW   = IDW_DEF,   // must equal clog2(NREQ)
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  uart_tx_arbiter_if.slave     bus,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 sent_pulse,
  output logic [CNT_W-1:0]     sent_count
);

  logic [1:0]      state;
  logic [NREQ-1:0] full;
  logic [7:0]      hold_dat [NREQ];
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic            any_full;
  logic            grant;

  uart_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .full   (full),
    .ptr    (ptr),
    .winner (winner),
    .any    (any_full)
  );

  // A grant only happens from IDLE; en low holds off new frames but never
  // interrupts one already in SEND/STOP.
  assign grant         = (state == ST_IDLE) && en && any_full;
  assign bus.req_ready = ~full;
  assign busy          = (state != ST_IDLE) || (|full);

  // Holding buffers. Accept and grant never hit the same slot on one edge:
  // accept needs the slot empty, grant needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < NREQ; i++) hold_dat[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !full[i]) begin
          hold_dat[i] <= bus.req_data[8*i +: 8];
          full[i]     <= 1'b1;
        end
      end
      if (grant) full[winner] <= 1'b0;
    end
  end

  // Frame sequencer. tx_ready drops on the edge that sees tx_done, and STOP
  // waits for tx_done to fall, so the transmitter never sees a fresh
  // "data prepared" while it is still flagging the previous frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.tx_data  <= 8'h00;
      bus.tx_ready <= 1'b0;
      grant_id     <= '0;
      ptr          <= '0;
      sent_pulse   <= 1'b0;
      sent_count   <= '0;
    end else begin
      sent_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            bus.tx_data  <= hold_dat[winner];
            grant_id     <= winner;
            ptr          <= IDW'(rr_next(int'(winner), NREQ));
            bus.tx_ready <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.tx_done) begin
            bus.tx_ready <= 1'b0;
            state        <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!bus.tx_done) begin
            sent_pulse <= 1'b1;
            sent_count <= sent_count + {{(CNT_W-1){1'b0}}, 1'b1};
            state      <= ST_IDLE;
          end
        end
        default: begin
          bus.tx_ready <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a simple transmitter model.
// Ports: none; drives the interface as master, sent_count is 4 bits to exercise wrap.
// Expected frame orders and counts are written out by hand for each step.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       busy;
  logic [1:0] grant_id;
  logic       sent_pulse;
  logic [3:0] sent_count;

  uart_tx_arbiter_if #(.NREQ(4)) bus ();

  uart_tx_arbiter #(
    .NREQ  (4),
    .IDW   (2),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .busy       (busy),
    .grant_id   (grant_id),
    .sent_pulse (sent_pulse),
    .sent_count (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         pulse_cnt    = 0;
  int         double_pulse = 0;
  int         dup_viol     = 0;
  int         tx_delay     = 20;
  int         done_len     = 3;
  logic [7:0] frames [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Transmitter model: after tx_ready, wait tx_delay cycles, record the byte,
  // then hold tx_done for done_len cycles. tx_ready must be low after the first.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_ready && !bus.tx_done) begin
        repeat (tx_delay) @(negedge clk);
        frames.push_back(bus.tx_data);
        bus.tx_done = 1'b1;
        for (int k = 0; k < done_len; k++) begin
          @(negedge clk);
          if (bus.tx_ready) dup_viol++;
        end
        bus.tx_done = 1'b0;
      end
    end
  end

  // sent_pulse monitor, sampled 1ns after the active edge.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sent_pulse) begin
        pulse_cnt++;
        if (prev) double_pulse++;
      end
      prev = sent_pulse;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic load(input logic [3:0] mask, input logic [31:0] dat);
    bus.req_valid = mask;
    bus.req_data  = dat;
    @(negedge clk);
    bus.req_valid = 4'b0000;
  endtask

  task automatic wait_pulses(input int n, input string tag);
    int target;
    int budget;
    target = pulse_cnt + n;
    budget = 0;
    while (pulse_cnt < target && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    chk(tag, 32'(pulse_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frames.delete();
  endtask

  initial begin
    int p0;
    int hi_cnt;
    rst           = 1'b1;
    en            = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_data  = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(bus.req_ready), 32'hF);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_sent_pulse", 32'(sent_pulse), 32'd0);
    chk("rst_sent_count", 32'(sent_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte from req0
    load(4'b0001, 32'h0000_0041);
    chk("acc_req_ready", 32'(bus.req_ready), 32'hE);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_no_tx_ready", 32'(bus.tx_ready), 32'd0);
    @(negedge clk);
    chk("grant_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("grant_tx_data", 32'(bus.tx_data), 32'h41);
    chk("grant_id0", 32'(grant_id), 32'd0);
    chk("grant_freed", 32'(bus.req_ready), 32'hF);
    p0 = pulse_cnt;
    wait_pulses(1, "single_timeout");
    chk("single_count", 32'(sent_count), 32'd1);
    chk("single_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("single_frames", 32'(frames.size()), 32'd1);
    chk("single_byte", 32'(frames[0]), 32'h41);
    chk("single_idle_tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Contention: all four in one cycle, then req0/req2 again
    tx_delay = 4;
    do_reset();
    load(4'b1111, 32'h1312_1110);
    wait_pulses(4, "cont_timeout");
    chk("cont_f0", 32'(frames[0]), 32'h10);
    chk("cont_f1", 32'(frames[1]), 32'h11);
    chk("cont_f2", 32'(frames[2]), 32'h12);
    chk("cont_f3", 32'(frames[3]), 32'h13);
    chk("cont_count4", 32'(sent_count), 32'd4);
    load(4'b0101, 32'h0012_0010);
    wait_pulses(2, "reload_timeout");
    chk("reload_f4", 32'(frames[4]), 32'h10);
    chk("reload_f5", 32'(frames[5]), 32'h12);
    chk("reload_grant", 32'(grant_id), 32'd2);
    chk("reload_count6", 32'(sent_count), 32'd6);

    // No duplicate frames with a long tx_done
    done_len = 10;
    p0 = pulse_cnt;
    load(4'b0011, 32'h0000_2221);
    wait_pulses(2, "nodup_timeout");
    repeat (15) @(negedge clk);
    chk("nodup_f6", 32'(frames[6]), 32'h21);
    chk("nodup_f7", 32'(frames[7]), 32'h22);
    chk("nodup_frames", 32'(frames.size()), 32'd8);
    chk("nodup_pulses", 32'(pulse_cnt - p0), 32'd2);
    chk("nodup_overlap", 32'(dup_viol), 32'd0);
    chk("nodup_double_pulse", 32'(double_pulse), 32'd0);
    chk("nodup_count8", 32'(sent_count), 32'd8);
    done_len = 3;

    // en gating
    en = 1'b0;
    load(4'b1000, 32'h3300_0000);
    hi_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.tx_ready) hi_cnt++;
    end
    chk("en_low_no_tx", 32'(hi_cnt), 32'd0);
    chk("en_low_busy", 32'(busy), 32'd1);
    chk("en_low_req_ready", 32'(bus.req_ready), 32'h7);
    en = 1'b1;
    @(negedge clk);
    chk("en_grant_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("en_grant_id", 32'(grant_id), 32'd3);
    chk("en_grant_data", 32'(bus.tx_data), 32'h33);
    en = 1'b0;
    wait_pulses(1, "en_midframe_timeout");
    chk("en_midframe_byte", 32'(frames[8]), 32'h33);
    chk("en_midframe_count", 32'(sent_count), 32'd9);
    en = 1'b1;

    // Async reset during SEND
    load(4'b0011, 32'h0000_6655);
    @(negedge clk);
    chk("mid_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("mid_tx_data", 32'(bus.tx_data), 32'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'hF);
    chk("arst_sent_count", 32'(sent_count), 32'd0);
    chk("arst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst_dropped_count", 32'(sent_count), 32'd0);
    chk("arst_dropped_busy", 32'(busy), 32'd0);
    frames.delete();

    // sent_count wrap at 4 bits
    tx_delay = 2;
    done_len = 1;
    p0 = pulse_cnt;
    for (int k = 0; k < 16; k++) begin
      load(4'b0001, 32'(k));
      wait_pulses(1, "wrap_timeout");
    end
    chk("wrap_16_count", 32'(sent_count), 32'd0);
    load(4'b0001, 32'h0000_00AA);
    wait_pulses(1, "wrap_timeout17");
    chk("wrap_17_count", 32'(sent_count), 32'd1);
    chk("wrap_pulses", 32'(pulse_cnt - p0), 32'd17);
    frames.delete();

    // req1/req3 continually refilled
    bus.req_data  = 32'hB300_B100;
    bus.req_valid = 4'b1010;
    wait_pulses(6, "prio_timeout");
    bus.req_valid = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] exp_b;
`ifdef UART_ARB_FIXED_PRIO_EN
      exp_b = 8'hB1;
`else
      exp_b = (k % 2 == 0) ? 8'hB1 : 8'hB3;
`endif
      chk($sformatf("prio_f%0d", k), 32'(frames[k]), 32'(exp_b));
    end
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
